// File: rtl/ic_test_sequencer.sv
// ic_test_sequencer: debounced start, sweep-gated checker enable and latched pass/fail/err verdict.
// Define IC_SEQ_AUTORETEST_EN to re-run the test automatically after HOLD_CYCLES in DONE.
module ic_test_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SWEEP_CYCLES    = 800_000_016,
    parameter int unsigned NUM_SWEEPS      = 2,
    parameter int unsigned SETTLE_CYCLES   = 4
`ifdef IC_SEQ_AUTORETEST_EN
    ,
    parameter int unsigned HOLD_CYCLES     = 50_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_key_n,
    input  logic [2:0] ic_sel,
    input  logic       chk_pass,
    input  logic       chk_fail,
    output logic       chk_enable,
    output logic [2:0] ic_sel_q,
    output logic       busy,
    output logic       done,
    output logic       result_pass,
    output logic       result_fail,
    output logic       result_err,
    output logic [3:0] sweep_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;
    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, key_q, start_evt_q, db_hit, sweep_end;
    logic [31:0] db_cnt_q, cyc_q, cyc_d, swp_q, swp_d;
    logic [2:0]  sel_d, res_q, res_d;
    assign db_hit      = (sync2_q != key_q) && (db_cnt_q == DEBOUNCE_CYCLES - 1);
    assign busy        = (state_q == RUN) || (state_q == SETTLE);
    assign done        = state_q == DONE;
    assign sweep_end   = cyc_q == SWEEP_CYCLES - 1;
    assign result_pass = res_q[0];
    assign result_fail = res_q[1];
    assign result_err  = res_q[2];
    assign sweep_cnt   = (swp_q > 32'd15) ? 4'd15 : swp_q[3:0];
    // key_q is the accepted (debounced) level; a press is its 1->0 acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            key_q       <= 1'b1;
            db_cnt_q    <= '0;
            start_evt_q <= 1'b0;
        end else begin
            sync1_q     <= start_key_n;
            sync2_q     <= sync1_q;
            start_evt_q <= db_hit && !sync2_q;
            if (sync2_q == key_q) begin
                db_cnt_q <= '0;
            end else if (db_hit) begin
                db_cnt_q <= '0;
                key_q    <= sync2_q;
            end else begin
                db_cnt_q <= db_cnt_q + 32'd1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        swp_d   = swp_q;
        sel_d   = ic_sel_q;
        res_d   = res_q;
        if (start_evt_q && !busy) begin
            state_d = RUN;
            cyc_d   = '0;
            swp_d   = '0;
            sel_d   = ic_sel;
            res_d   = '0;
        end else if (start_evt_q) begin
            state_d = IDLE;
            cyc_d   = '0;
            swp_d   = '0;
            res_d   = '0;
        end else if (state_q == RUN) begin
            cyc_d = sweep_end ? '0 : cyc_q + 32'd1;
            swp_d = sweep_end ? swp_q + 32'd1 : swp_q;
            state_d = (sweep_end && swp_q == NUM_SWEEPS - 1) ? SETTLE : RUN;
        end else if (state_q == SETTLE) begin
            cyc_d = cyc_q + 32'd1;
            if (cyc_q == SETTLE_CYCLES) begin
                state_d = DONE;
                cyc_d   = '0;
                res_d   = {chk_pass == chk_fail, chk_fail && !chk_pass, chk_pass && !chk_fail};
            end
`ifdef IC_SEQ_AUTORETEST_EN
        end else if (state_q == DONE) begin
            cyc_d = cyc_q + 32'd1;
            if (cyc_q == HOLD_CYCLES - 1) begin
                state_d = RUN;
                cyc_d   = '0;
                swp_d   = '0;
            end
        end
`else
        end
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            swp_q      <= '0;
            ic_sel_q   <= '0;
            res_q      <= '0;
            chk_enable <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            swp_q      <= swp_d;
            ic_sel_q   <= sel_d;
            res_q      <= res_d;
            chk_enable <= state_d == RUN;
        end
    end
endmodule

// File: tb/tb_ic_test_sequencer.sv
// tb_ic_test_sequencer: randomized scoreboard bench for ic_test_sequencer (default build).
module tb_ic_test_sequencer;
    localparam int SWEEP = 20, NSW = 2;
    logic clk = 1'b0, rst_n = 1'b0, start_key_n = 1'b1, chk_pass = 1'b0, chk_fail = 1'b0;
    logic [2:0] ic_sel = 3'd0;
    logic chk_enable, busy, done, result_pass, result_fail, result_err;
    logic [2:0] ic_sel_q;
    logic [3:0] sweep_cnt;
    typedef struct {logic [2:0] sel; logic p; logic f; logic e;} exp_t;
    exp_t q[$];
    exp_t x;
    int tests = 0, fails = 0, en_cnt = 0;
    logic done_prev = 1'b0, busy_prev = 1'b0, saw;
    always #5 clk = ~clk;
    ic_test_sequencer #(
        .DEBOUNCE_CYCLES(4), .SWEEP_CYCLES(SWEEP), .NUM_SWEEPS(NSW), .SETTLE_CYCLES(4)
`ifdef IC_SEQ_AUTORETEST_EN
        , .HOLD_CYCLES(10)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_key_n(start_key_n), .ic_sel(ic_sel),
        .chk_pass(chk_pass), .chk_fail(chk_fail), .chk_enable(chk_enable),
        .ic_sel_q(ic_sel_q), .busy(busy), .done(done), .result_pass(result_pass),
        .result_fail(result_fail), .result_err(result_err), .sweep_cnt(sweep_cnt)
    );
    task automatic chk(string n, int a, int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask
    // monitor: measures enable length per test, checks verdict on each DONE entry
    always @(negedge clk) begin
        if (busy && !busy_prev) en_cnt = 0;
        if (chk_enable) en_cnt++;
        if (done && !done_prev) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                x = q.pop_front();
                chk("ic_sel_q", int'(ic_sel_q), int'(x.sel));
                chk("result_pass", int'(result_pass), int'(x.p));
                chk("result_fail", int'(result_fail), int'(x.f));
                chk("result_err", int'(result_err), int'(x.e));
                chk("sweep_cnt", int'(sweep_cnt), NSW);
                chk("enable_cycles", en_cnt, NSW * SWEEP);
                chk("busy_in_done", int'(busy), 0);
            end
        end
        done_prev = done;
        busy_prev = busy;
    end
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic press(int n);
        start_key_n = 1'b0;
        cyc(n);
        start_key_n = 1'b1;
        cyc(n);
    endtask
    task automatic wait_done();
        int k = 0;
        while (!done && k < 300) begin
            cyc(1);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask
    task automatic run_test(logic [2:0] sel, logic p, logic f);
        ic_sel   = sel;
        chk_pass = p;
        chk_fail = f;
        q.push_back('{sel, p && !f, f && !p, p == f});
        press(8);
        chk("busy_after_start", int'(busy), 1);
        chk("results_cleared", int'({result_pass, result_fail, result_err}), 0);
        ic_sel = ~sel;
        wait_done();
        cyc(2);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        logic [2:0] s;
        logic p, f;
        cyc(3);
        chk("reset_outputs", int'({chk_enable, busy, done, result_pass, result_fail,
            result_err, sweep_cnt, ic_sel_q}), 0);
        rst_n = 1'b1;
        cyc(2);
        saw = 1'b0;
        repeat (5) begin
            start_key_n = 1'b0;
            repeat (3) begin cyc(1); saw = saw | busy | chk_enable; end
            start_key_n = 1'b1;
            repeat (3) begin cyc(1); saw = saw | busy | chk_enable; end
        end
        repeat (10) begin cyc(1); saw = saw | busy | chk_enable; end
        chk("bounce_no_start", int'(saw), 0);
        run_test(3'b001, 1'b1, 1'b0);
        run_test(3'b010, 1'b0, 1'b1);
        run_test(3'b101, 1'b1, 1'b1);
        run_test(3'b110, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            s = 3'($urandom);
            p = 1'($urandom);
            f = 1'($urandom);
            run_test(s, p, f);
        end
        ic_sel = 3'd3;
        press(8);
        chk("abort_started", int'(busy), 1);
        cyc(10);
        press(8);
        chk("abort_outputs", int'({busy, done, chk_enable, result_pass, result_fail,
            result_err}), 0);
        saw = 1'b0;
        repeat (30) begin cyc(1); saw = saw | busy | done; end
        chk("abort_no_restart", int'(saw), 0);
        press(8);
        cyc(5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", int'({chk_enable, busy, done, result_pass,
            result_fail, result_err, sweep_cnt, ic_sel_q}), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("post_reset_idle", int'(busy), 0);
        run_test(3'b100, 1'b1, 1'b0);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
